// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment scan decoder and the matching
// encoder: the active-low segment table for hex 0..F, the active-low anode
// select codes, and the scan-state encoding.
// Segment patterns are written exactly as they appear on seg[6:0].
// -----------------------------------------------------------------------------
package seg7_pkg;

  typedef enum logic {
    StScan  = 1'b0,
    StBlank = 1'b1
  } scan_state_e;

  localparam logic [3:0] AnodeBlank  = 4'b1111;
  localparam logic [3:0] AnodeDigit0 = 4'b0111;
  localparam logic [3:0] AnodeDigit1 = 4'b1011;
  localparam logic [3:0] AnodeDigit2 = 4'b1101;
  localparam logic [3:0] AnodeDigit3 = 4'b1110;

  localparam logic [6:0] SegOff = 7'b1111111;

  // Entry i is the pattern that decodes to hex value i.
  localparam logic [15:0][6:0] SegPatterns = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // D
    7'b0110001,  // C
    7'b1100000,  // B
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  // True only for the four legal single-digit selects.
  function automatic logic anode_is_digit(input logic [3:0] anode);
    return (anode == AnodeDigit0) || (anode == AnodeDigit1) ||
           (anode == AnodeDigit2) || (anode == AnodeDigit3);
  endfunction

  // Digit index for a legal select; callers qualify with anode_is_digit.
  function automatic logic [1:0] anode_to_digit(input logic [3:0] anode);
    logic [1:0] digit;
    case (anode)
      AnodeDigit1: digit = 2'd1;
      AnodeDigit2: digit = 2'd2;
      AnodeDigit3: digit = 2'd3;
      default:     digit = 2'd0;
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// -----------------------------------------------------------------------------
// seg7_pattern_decode
// Combinational lookup from an active-low segment pattern to its hex value.
// Ports:
//   i_pattern  [6:0]  active-low segment pattern
//   o_hex      [3:0]  decoded value, 0 when the pattern is not recognised
//   o_invalid         1 when the pattern matches no table entry
// -----------------------------------------------------------------------------
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic [3:0] o_hex,
  output logic       o_invalid
);

  always_comb begin
    o_hex     = 4'h0;
    o_invalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i_pattern == SegPatterns[i]) begin
        o_hex     = 4'(i);
        o_invalid = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
// Snoops a multiplexed four-digit seven-segment display bus and rebuilds the
// displayed 16-bit hex value. A digit is captured once its select and pattern
// have been steady for STABLE_CYCLES registered samples; a frame is published
// when all four digits have been captured. A long all-blank period discards a
// partially gathered frame.
// Parameters:
//   STABLE_CYCLES  identical samples needed before a capture (2..255)
//   BLANK_TIMEOUT  consecutive blank samples that discard a partial frame
// Ports:
//   clk           clock, rising edge
//   reset         synchronous, active-high
//   anode  [3:0]  active-low digit select (0111 = digit 0 .. 1110 = digit 3)
//   seg    [6:0]  active-low segment pattern
//   value  [15:0] last complete frame, digit 0 in [15:12]
//   frame_valid   one-cycle pulse when value updates
//   frame_err     set with value when any digit of that frame was unrecognised
//   digit_strobe  one-cycle pulse on every digit capture
// -----------------------------------------------------------------------------
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned BLANK_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anode,
  input  logic [6:0]  seg,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        digit_strobe
);

  localparam int unsigned BlankW = $clog2(BLANK_TIMEOUT + 1);

  // Input stage and the sample before it, for the stability compare.
  logic [3:0]            r_anode;
  logic [6:0]            r_seg;
  logic [3:0]            r_prev_anode;
  logic [6:0]            r_prev_seg;

  logic [7:0]            r_stab_cnt;
  logic [BlankW-1:0]     r_blank_cnt;
  scan_state_e           r_state;

  // Partial frame being gathered.
  logic [3:0]            r_seen;
  logic [3:0][3:0]       r_shadow;
  logic                  r_shadow_err;

  logic [15:0]           r_value;
  logic                  r_frame_valid;
  logic                  r_frame_err;
  logic                  r_digit_strobe;

  logic                  w_onehot;
  logic                  w_blank;
  logic                  w_same;
  logic                  w_capture;
  logic                  w_frame_done;
  logic                  w_timeout;
  logic [1:0]            w_digit;
  logic [3:0]            w_hex;
  logic                  w_invalid;
  logic [3:0]            w_seen_next;
  logic [3:0][3:0]       w_shadow_next;

  seg7_pattern_decode u_decode (
    .i_pattern (r_seg),
    .o_hex     (w_hex),
    .o_invalid (w_invalid)
  );

  assign w_onehot = anode_is_digit(r_anode);
  assign w_blank  = (r_anode == AnodeBlank);
  assign w_same   = ({r_anode, r_seg} == {r_prev_anode, r_prev_seg});
  assign w_digit  = anode_to_digit(r_anode);

  // The counter holds STABLE_CYCLES-1 on exactly one edge per steady run, so
  // this fires once and the saturated counter suppresses any repeat.
  assign w_capture    = w_onehot && w_same && (r_stab_cnt == 8'(STABLE_CYCLES - 1));
  assign w_seen_next  = r_seen | (4'b0001 << w_digit);
  assign w_frame_done = w_capture && (w_seen_next == 4'hF);
  assign w_timeout    = w_blank && (r_blank_cnt == BlankW'(BLANK_TIMEOUT - 1));

  always_comb begin
    w_shadow_next          = r_shadow;
    w_shadow_next[w_digit] = w_hex;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_anode        <= AnodeBlank;
      r_seg          <= SegOff;
      r_prev_anode   <= AnodeBlank;
      r_prev_seg     <= SegOff;
      r_stab_cnt     <= '0;
      r_blank_cnt    <= '0;
      r_state        <= StBlank;
      r_seen         <= '0;
      r_shadow       <= '0;
      r_shadow_err   <= 1'b0;
      r_value        <= '0;
      r_frame_valid  <= 1'b0;
      r_frame_err    <= 1'b0;
      r_digit_strobe <= 1'b0;
    end else begin
      r_anode      <= anode;
      r_seg        <= seg;
      r_prev_anode <= r_anode;
      r_prev_seg   <= r_seg;

      if (!w_onehot || !w_same) begin
        r_stab_cnt <= 8'd1;
      end else if (r_stab_cnt != 8'(STABLE_CYCLES)) begin
        r_stab_cnt <= r_stab_cnt + 8'd1;
      end

      r_digit_strobe <= w_capture;
      r_frame_valid  <= w_frame_done;

      // Capture and timeout are exclusive: one needs a digit select, the
      // other a blank one.
      if (w_capture) begin
        r_shadow <= w_shadow_next;
        if (w_frame_done) begin
          r_value      <= {w_shadow_next[0], w_shadow_next[1],
                           w_shadow_next[2], w_shadow_next[3]};
          r_frame_err  <= r_shadow_err | w_invalid;
          r_seen       <= '0;
          r_shadow_err <= 1'b0;
        end else begin
          r_seen       <= w_seen_next;
          r_shadow_err <= r_shadow_err | w_invalid;
        end
      end else if (w_timeout) begin
        r_seen       <= '0;
        r_shadow_err <= 1'b0;
      end

      // Counts consecutive blank samples; every blank sample is (or moves the
      // FSM into) BLANK, so the count is only ever live in that state.
      if (w_blank) begin
        if (r_blank_cnt != BlankW'(BLANK_TIMEOUT)) begin
          r_blank_cnt <= r_blank_cnt + BlankW'(1);
        end
      end else begin
        r_blank_cnt <= '0;
      end

      // Multi-hot samples match neither branch and leave the state alone.
      unique case (r_state)
        StScan:  if (w_blank)  r_state <= StBlank;
        StBlank: if (w_onehot) r_state <= StScan;
      endcase
    end
  end

  assign value        = r_value;
  assign frame_valid  = r_frame_valid;
  assign frame_err    = r_frame_err;
  assign digit_strobe = r_digit_strobe;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
module tb_seg7_scan_decoder;

  localparam int S  = 4;
  localparam int TO = 1024;

  localparam logic [6:0] Pat [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  anode = 4'hF;
  logic [6:0]  seg = 7'h7F;
  logic [15:0] value;
  logic        frame_valid;
  logic        frame_err;
  logic        digit_strobe;

  seg7_scan_decoder #(
    .STABLE_CYCLES (S),
    .BLANK_TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .anode        (anode),
    .seg          (seg),
    .value        (value),
    .frame_valid  (frame_valid),
    .frame_err    (frame_err),
    .digit_strobe (digit_strobe)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_strobe = 0;
  int n_fv = 0;

  // Model: history of registered samples, {reset_marker, anode, seg}.
  logic [11:0] hist [$];
  logic [3:0]  m_seen = '0;
  logic [3:0]  m_sh [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
  logic        m_err = 1'b0;
  logic [15:0] m_value = '0;
  logic        m_ferr = 1'b0;
  logic        m_fv = 1'b0;
  logic        m_strobe = 1'b0;

  function automatic logic is_digit(input logic [3:0] a);
    return $countones(~a) == 1;
  endfunction

  // Length of the run of identical digit-select samples ending at the newest.
  function automatic int stab_run();
    int n;
    logic [11:0] last;
    last = hist[hist.size() - 1];
    if (last[11] || !is_digit(last[10:7])) return 0;
    n = 1;
    for (int i = hist.size() - 2; i >= 0 && n <= S; i--) begin
      if (hist[i] != last) break;
      n++;
    end
    return n;
  endfunction

  // Consecutive blank samples ending at the newest; a reset sample counts
  // itself but nothing older.
  function automatic int blank_run();
    int n;
    n = 0;
    for (int i = hist.size() - 1; i >= 0 && n <= TO; i--) begin
      if (hist[i][10:7] != 4'hF) break;
      n++;
      if (hist[i][11]) break;
    end
    return n;
  endfunction

  task automatic model_step();
    logic [11:0] e;
    int d;
    logic [3:0] hex;
    logic inv;
    m_strobe = 1'b0;
    m_fv = 1'b0;
    if (hist.size() == 0) return;
    e = hist[hist.size() - 1];
    if (stab_run() == S) begin
      d = 0;
      for (int b = 0; b < 4; b++) if (!e[7 + b]) d = 3 - b;
      hex = 4'h0;
      inv = 1'b1;
      for (int i = 0; i < 16; i++) begin
        if (Pat[i] == e[6:0]) begin
          hex = i[3:0];
          inv = 1'b0;
        end
      end
      m_sh[d] = hex;
      m_err = m_err | inv;
      m_seen[d] = 1'b1;
      m_strobe = 1'b1;
      if (m_seen == 4'hF) begin
        m_value = {m_sh[0], m_sh[1], m_sh[2], m_sh[3]};
        m_ferr = m_err;
        m_fv = 1'b1;
        m_seen = '0;
        m_err = 1'b0;
      end
    end else if (blank_run() == TO) begin
      m_seen = '0;
      m_err = 1'b0;
    end
  endtask

  // Compare process: advance the model on every edge, check 1 time unit later.
  always @(posedge clk) begin : cmp
    logic [11:0] smp;
    if (reset) begin
      smp = {1'b1, 4'hF, 7'h7F};
      m_seen = '0;
      for (int i = 0; i < 4; i++) m_sh[i] = 4'h0;
      m_err = 1'b0;
      m_value = '0;
      m_ferr = 1'b0;
      m_fv = 1'b0;
      m_strobe = 1'b0;
    end else begin
      smp = {1'b0, anode, seg};
      model_step();
    end
    hist.push_back(smp);
    #1;
    n_vec++;
    if ({value, frame_valid, frame_err, digit_strobe} !==
        {m_value, m_fv, m_ferr, m_strobe}) begin
      n_err++;
      $display("FAIL cycle_check t=%0t got value=%h fv=%b ferr=%b strobe=%b want value=%h fv=%b ferr=%b strobe=%b",
               $time, value, frame_valid, frame_err, digit_strobe,
               m_value, m_fv, m_ferr, m_strobe);
    end
    if (digit_strobe === 1'b1) n_strobe++;
    if (frame_valid === 1'b1) n_fv++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic cyc(input logic [3:0] a, input logic [6:0] s, input int n);
    repeat (n) begin
      @(negedge clk);
      anode = a;
      seg = s;
    end
  endtask

  task automatic scan_digit(input int d, input logic [6:0] s);
    logic [3:0] a;
    a = 4'hF;
    a[3 - d] = 1'b0;
    cyc(a, s, 8);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    anode = 4'hF;
    seg = 7'h7F;
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    n_strobe = 0;
    n_fv = 0;
  endtask

  initial begin
    do_reset(3);
    chk("reset_value", value, 16'h0000);
    chk("reset_fv", frame_valid, 0);
    reset = 1'b0;

    // Basic frame 1,2,3,4
    clr();
    for (int d = 0; d < 4; d++) scan_digit(d, Pat[d + 1]);
    cyc(4'hF, 7'h7F, 4);
    chk("f1234_strobes", n_strobe, 4);
    chk("f1234_frames", n_fv, 1);
    chk("f1234_value", value, 16'h1234);
    chk("f1234_err", frame_err, 0);
    chk("model_pin_1234", m_value, 16'h1234);

    // Stability threshold: 3 samples too few, 4 exactly enough
    clr();
    cyc(4'b0111, Pat[5], 3);
    cyc(4'hF, 7'h7F, 4);
    chk("hold3_no_strobe", n_strobe, 0);
    cyc(4'b0111, Pat[5], 4);
    cyc(4'hF, 7'h7F, 4);
    chk("hold4_one_strobe", n_strobe, 1);

    // Unrecognised pattern on digit 2, then a clean frame
    do_reset(2);
    reset = 1'b0;
    clr();
    scan_digit(0, Pat[1]);
    scan_digit(1, Pat[2]);
    scan_digit(2, 7'b1111110);
    scan_digit(3, Pat[4]);
    cyc(4'hF, 7'h7F, 4);
    chk("bad_frames", n_fv, 1);
    chk("bad_nibble", value[7:4], 0);
    chk("bad_value", value, 16'h1204);
    chk("bad_err", frame_err, 1);
    clr();
    for (int d = 0; d < 4; d++) scan_digit(d, Pat[d + 5]);
    cyc(4'hF, 7'h7F, 4);
    chk("clean_frames", n_fv, 1);
    chk("clean_value", value, 16'h5678);
    chk("clean_err", frame_err, 0);

    // Blank timeout discards digits 0,1
    do_reset(2);
    reset = 1'b0;
    clr();
    scan_digit(0, Pat[1]);
    scan_digit(1, Pat[2]);
    cyc(4'hF, 7'h7F, TO);
    scan_digit(2, Pat[10]);
    scan_digit(3, Pat[11]);
    scan_digit(0, Pat[12]);
    chk("timeout_no_early_frame", n_fv, 0);
    scan_digit(1, Pat[13]);
    cyc(4'hF, 7'h7F, 4);
    chk("timeout_frames", n_fv, 1);
    chk("timeout_value", value, 16'hCDAB);

    // One blank short of the timeout keeps the partial frame
    do_reset(2);
    reset = 1'b0;
    clr();
    scan_digit(0, Pat[1]);
    scan_digit(1, Pat[2]);
    cyc(4'hF, 7'h7F, TO - 1);
    scan_digit(2, Pat[10]);
    scan_digit(3, Pat[11]);
    cyc(4'hF, 7'h7F, 4);
    chk("short_blank_frames", n_fv, 1);
    chk("short_blank_value", value, 16'h12AB);

    // Reset mid-frame discards captures
    clr();
    scan_digit(0, Pat[1]);
    scan_digit(1, Pat[2]);
    scan_digit(2, Pat[3]);
    do_reset(2);
    chk("midrst_value", value, 16'h0000);
    chk("midrst_err", frame_err, 0);
    chk("midrst_fv", frame_valid, 0);
    chk("midrst_strobe", digit_strobe, 0);
    reset = 1'b0;
    clr();
    scan_digit(3, Pat[4]);
    cyc(4'hF, 7'h7F, 4);
    chk("midrst_no_frame", n_fv, 0);
    chk("midrst_value_after", value, 16'h0000);

    // Multi-hot select is never captured
    clr();
    cyc(4'b0011, Pat[1], 20);
    cyc(4'hF, 7'h7F, 4);
    chk("multihot_no_strobe", n_strobe, 0);
    scan_digit(0, Pat[1]);
    cyc(4'hF, 7'h7F, 4);
    chk("after_multihot_strobe", n_strobe, 1);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
